// File: rtl/xn_table_gen_if.sv
// xn_table_gen_if: bundle between a Montgomery precompute stage and its controller/core.
//   start_p       one-cycle start request (controller -> generator)
//   b, m          multiplicand and odd modulus, sampled when start_p is accepted
//   bxn[1:ML-1]   multiples j*b
//   mxn[0:ML-1]   residue-indexed multiples of m; mxn[0] is always 0
//   busy, tables_valid, m_err, done_irq_p   status back to the controller
interface xn_table_gen_if #(
  parameter int NBITS = 2048,
  parameter int PBITS = 1
);
  localparam int MLSIZE = 1 << PBITS;
  localparam int W      = NBITS + PBITS;

  logic             start_p;
  logic [NBITS-1:0] b;
  logic [NBITS-1:0] m;
  logic [W-1:0]     bxn [1:MLSIZE-1];
  logic [W-1:0]     mxn [0:MLSIZE-1];
  logic             busy;
  logic             tables_valid;
  logic             m_err;
  logic             done_irq_p;

  modport master (
    output start_p, b, m,
    input  bxn, mxn, busy, tables_valid, m_err, done_irq_p
  );

  modport slave (
    input  start_p, b, m,
    output bxn, mxn, busy, tables_valid, m_err, done_irq_p
  );
endinterface

// File: rtl/xn_table_gen.sv
// xn_table_gen: builds the bxn (j*b) and mxn (k*m with r + k*m = 0 mod 2^PBITS)
// tables for a radix-2^PBITS Montgomery core, one entry per cycle.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    xn_table_gen_if slave modport (start_p, b, m in; tables and status out)
module xn_table_gen #(
  parameter int NBITS = 2048,
  parameter int PBITS = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  xn_table_gen_if.slave  bus
);
  localparam int MLSIZE = 1 << PBITS;
  localparam int W      = NBITS + PBITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GEN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [NBITS-1:0] b_q;
  logic [NBITS-1:0] m_q;
  logic [W-1:0]     acc_b_q;
  logic [W-1:0]     acc_m_q;
  logic [PBITS-1:0] j_q;
  logic [W-1:0]     bxn_q [1:MLSIZE-1];
  logic [W-1:0]     mxn_q [0:MLSIZE-1];
  logic             busy_q;
  logic             valid_q;
  logic             m_err_q;
  logic             done_q;

  logic [W-1:0]     acc_b_d;
  logic [W-1:0]     acc_m_d;
  logic [PBITS-1:0] r_d;
  logic [PBITS-1:0] j_d;

  // Running sums j*b and j*m; r is the residue slot that j*m cancels.
  always_comb begin
    acc_b_d = acc_b_q + W'(b_q);
    acc_m_d = acc_m_q + W'(m_q);
    r_d     = '0 - acc_m_d[PBITS-1:0];
    j_d     = j_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      b_q     <= '0;
      m_q     <= '0;
      acc_b_q <= '0;
      acc_m_q <= '0;
      j_q     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      m_err_q <= 1'b0;
      done_q  <= 1'b0;
      for (int unsigned i = 1; i < MLSIZE; i++) bxn_q[i] <= '0;
      for (int unsigned i = 0; i < MLSIZE; i++) mxn_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_GEN: begin
          bxn_q[j_q] <= acc_b_d;
          mxn_q[r_d] <= acc_m_d;
          acc_b_q    <= acc_b_d;
          acc_m_q    <= acc_m_d;
          j_q        <= j_d;
          if (j_q == PBITS'(MLSIZE - 1)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE accept a new start identically.
          state_q <= S_IDLE;
          if (bus.start_p) begin
            b_q     <= bus.b;
            m_q     <= bus.m;
            acc_b_q <= '0;
            acc_m_q <= '0;
            j_q     <= PBITS'(1);
            valid_q <= 1'b0;
            for (int unsigned i = 1; i < MLSIZE; i++) bxn_q[i] <= '0;
            for (int unsigned i = 0; i < MLSIZE; i++) mxn_q[i] <= '0;
            if (bus.m[0]) begin
              state_q <= S_GEN;
              busy_q  <= 1'b1;
              m_err_q <= 1'b0;
            end else begin
              // Even modulus: no table can satisfy the residue rule, report and finish.
              state_q <= S_DONE;
              m_err_q <= 1'b1;
              done_q  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.bxn          = bxn_q;
  assign bus.mxn          = mxn_q;
  assign bus.busy         = busy_q;
  assign bus.tables_valid = valid_q;
  assign bus.m_err        = m_err_q;
  assign bus.done_irq_p   = done_q;
endmodule

// File: tb/tb_xn_table_gen.sv
// tb_xn_table_gen: randomized and directed checks of xn_table_gen for
// NBITS=8 with PBITS=2 and PBITS=1, against a behavioural table model.
module tb_xn_table_gen;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  xn_table_gen_if #(.NBITS(8), .PBITS(2)) i2 ();
  xn_table_gen_if #(.NBITS(8), .PBITS(1)) i1 ();

  xn_table_gen #(.NBITS(8), .PBITS(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(i2.slave));
  xn_table_gen #(.NBITS(8), .PBITS(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: bxn[j] = j*b; mxn[r] = k*m with smallest k making r + k*m divisible by ml.
  function automatic longint exp_mxn(input longint mv, input int r, input int ml);
    for (int k = 0; k < ml; k++)
      if (((r + k * mv) % ml) == 0) return k * mv;
    return -1;
  endfunction

  task automatic check_tables2(input longint bv, input longint mv, input bit zero);
    for (int j = 1; j < 4; j++)
      check($sformatf("p2 bxn[%0d]", j), i2.bxn[j], zero ? 0 : j * bv);
    for (int r = 0; r < 4; r++)
      check($sformatf("p2 mxn[%0d]", r), i2.mxn[r], zero ? 0 : exp_mxn(mv, r, 4));
  endtask

  task automatic check_tables1(input longint bv, input longint mv, input bit zero);
    check("p1 bxn[1]", i1.bxn[1], zero ? 0 : bv);
    for (int r = 0; r < 2; r++)
      check($sformatf("p1 mxn[%0d]", r), i1.mxn[r], zero ? 0 : exp_mxn(mv, r, 2));
  endtask

  // One PBITS=2 run; optional re-assert of start_p in cycle restart_cyc.
  task automatic run_p2(input logic [7:0] bv, input logic [7:0] mv, input int restart_cyc);
    int dones;
    dones = 0;
    @(negedge clk);
    i2.start_p = 1'b1; i2.b = bv; i2.m = mv;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      i2.start_p = 1'b0;
      if (c == restart_cyc) begin
        i2.start_p = 1'b1; i2.b = ~bv; i2.m = mv ^ 8'h02;
      end
      if (i2.done_irq_p) dones++;
      check($sformatf("p2 busy c%0d", c), i2.busy, (c >= 1 && c <= 3) ? 1 : 0);
      check($sformatf("p2 done c%0d", c), i2.done_irq_p, (c == 4) ? 1 : 0);
      check($sformatf("p2 valid c%0d", c), i2.tables_valid, (c >= 4) ? 1 : 0);
      check($sformatf("p2 m_err c%0d", c), i2.m_err, 0);
      if (c == 1) check_tables2(0, 0, 1'b1);
      if (c == 4) check_tables2(bv, mv, 1'b0);
    end
    check("p2 done count", dones, 1);
  endtask

  task automatic run_p1(input logic [7:0] bv, input logic [7:0] mv);
    @(negedge clk);
    i1.start_p = 1'b1; i1.b = bv; i1.m = mv;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      i1.start_p = 1'b0;
      check($sformatf("p1 busy c%0d", c), i1.busy, (c == 1) ? 1 : 0);
      check($sformatf("p1 done c%0d", c), i1.done_irq_p, (c == 2) ? 1 : 0);
      check($sformatf("p1 valid c%0d", c), i1.tables_valid, (c >= 2) ? 1 : 0);
      if (c == 1) check_tables1(0, 0, 1'b1);
      if (c == 2) check_tables1(bv, mv, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] rb;
    logic [7:0] rm;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    i2.start_p = 1'b0; i2.b = '0; i2.m = '0;
    i1.start_p = 1'b0; i1.b = '0; i1.m = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst busy", i2.busy, 0);
    check("rst valid", i2.tables_valid, 0);
    check("rst m_err", i2.m_err, 0);
    check("rst done", i2.done_irq_p, 0);
    check_tables2(0, 0, 1'b1);
    check_tables1(0, 0, 1'b1);

    // Directed cases
    run_p2(8'd200, 8'd13, 0);
    run_p2(8'd255, 8'd255, 0);
    for (int r = 0; r < 4; r++)
      check($sformatf("p2 residue r%0d", r), (r + i2.mxn[r]) % 4, 0);
    run_p1(8'd7, 8'd9);

    // Even modulus, then recovery
    @(negedge clk);
    i2.start_p = 1'b1; i2.b = 8'd77; i2.m = 8'd12;
    @(negedge clk);
    i2.start_p = 1'b0;
    check("even done c1", i2.done_irq_p, 1);
    check("even m_err c1", i2.m_err, 1);
    check("even busy c1", i2.busy, 0);
    check("even valid c1", i2.tables_valid, 0);
    check_tables2(0, 0, 1'b1);
    @(negedge clk);
    check("even done c2", i2.done_irq_p, 0);
    check("even m_err c2", i2.m_err, 1);
    check("even busy c2", i2.busy, 0);
    run_p2(8'd99, 8'd13, 0);

    // start_p re-asserted mid-run is ignored
    run_p2(8'd123, 8'd45, 2);

    // Start accepted in the done cycle
    @(negedge clk);
    i2.start_p = 1'b1; i2.b = 8'd10; i2.m = 8'd3;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      i2.start_p = 1'b0;
      if (c == 4) begin
        check("b2b done1", i2.done_irq_p, 1);
        check_tables2(10, 3, 1'b0);
        i2.start_p = 1'b1; i2.b = 8'd201; i2.m = 8'd7;
      end
      if (c == 5) begin
        check("b2b valid drop", i2.tables_valid, 0);
        check("b2b busy", i2.busy, 1);
        check_tables2(0, 0, 1'b1);
      end
      if (c == 8) begin
        check("b2b done2", i2.done_irq_p, 1);
        check("b2b valid2", i2.tables_valid, 1);
        check_tables2(201, 7, 1'b0);
      end
    end

    // Reset in cycle 2 of a run
    @(negedge clk);
    i2.start_p = 1'b1; i2.b = 8'd150; i2.m = 8'd21;
    @(negedge clk);
    i2.start_p = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid rst busy", i2.busy, 0);
    check("mid rst valid", i2.tables_valid, 0);
    check("mid rst done", i2.done_irq_p, 0);
    check("mid rst m_err", i2.m_err, 0);
    check_tables2(0, 0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("post rst done %0d", c), i2.done_irq_p, 0);
      check($sformatf("post rst busy %0d", c), i2.busy, 0);
    end
    run_p2(8'd150, 8'd21, 0);

    // Randomized runs
    for (int n = 0; n < 20; n++) begin
      rb = 8'($urandom_range(0, 255));
      rm = 8'($urandom_range(0, 255)) | 8'd1;
      run_p2(rb, rm, 0);
      rb = 8'($urandom_range(0, 255));
      rm = 8'($urandom_range(0, 255)) | 8'd1;
      run_p1(rb, rm);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
